// File: rtl/sync_pulse_gen_mch.sv
// Multi-channel sync pulse generator: one master pulse plus normal pulses per cycle, fanned out to gated channels.
// Defining SYNC_EXT_IN_EN adds an external sync_in re-trigger input and cfg_ext_mode.
module sync_pulse_gen_mch #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 32,
  parameter int PULSES_W = 4
) (
  input  logic                clk50_clk,
  input  logic                rst_reset_n,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_blank_master,
  input  logic [CNT_W-1:0]    cfg_blank,
  input  logic [PULSES_W-1:0] cfg_n_pulses,
  input  logic                cfg_polarity,
  input  logic [CHANNELS-1:0] cfg_ch_enable,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                cmd_clear,
`ifdef SYNC_EXT_IN_EN
  input  logic                sync_in,
  input  logic                cfg_ext_mode,
`endif
  output logic                sync_out,
  output logic [CHANNELS-1:0] sync_ch,
  output logic                running,
  output logic [PULSES_W-1:0] pulse_idx,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic                cfg_err,
  output logic                irq_master,
  output logic                irq_cycle
);

  // Commands are single-cycle strobes with no back-pressure: each one is acted on
  // at the edge where it is sampled high, stop taking priority over start.
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [PULSES_W-1:0] idx, idx_n;
  logic [CNT_W-1:0]    sh_period, sh_blank_master, sh_blank;
  logic [PULSES_W-1:0] sh_n_pulses;

  logic                do_reload, load, cyc_inc, err_set, irq_m_n, irq_c_n;
  logic                active_n, level_n, cfg_ok, last_cnt, last_pulse;
  logic [CNT_W-1:0]    wm_n, per_n, width_n;
  logic [PULSES_W-1:0] np_n;
  logic                ext_edge, ext_mode;

`ifdef SYNC_EXT_IN_EN
  // [0],[1] form the synchronizer; [2] is the previous synchronized sample for edge detection.
  logic [2:0] sync_ff;

  always_ff @(posedge clk50_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) sync_ff <= '0;
    else              sync_ff <= {sync_ff[1:0], sync_in};
  end

  assign ext_edge = cfg_polarity ? (sync_ff[1] & ~sync_ff[2]) : (~sync_ff[1] & sync_ff[2]);
  assign ext_mode = cfg_ext_mode;
`else
  assign ext_edge = 1'b0;
  assign ext_mode = 1'b0;
`endif

  assign cfg_ok     = (cfg_period >= CNT_W'(2)) && (cfg_n_pulses != '0);
  assign last_cnt   = (cnt == sh_period - CNT_W'(1));
  assign last_pulse = (idx == sh_n_pulses - PULSES_W'(1));
  assign pulse_idx  = idx;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    do_reload = 1'b0;
    load      = 1'b0;
    cyc_inc   = 1'b0;
    err_set   = 1'b0;
    irq_m_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!cmd_stop && (cmd_start || ext_edge)) do_reload = 1'b1;
      end
      ST_RUN: begin
        if (cmd_stop) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (ext_mode && ext_edge) begin
          cyc_inc   = 1'b1;
          do_reload = 1'b1;
        end else if (last_cnt) begin
          if (last_pulse) begin
            cyc_inc = 1'b1;
            if (ext_mode) begin
              state_n = ST_HOLD;
              cnt_n   = '0;
              idx_n   = '0;
            end else begin
              do_reload = 1'b1;
            end
          end else begin
            cnt_n = '0;
            idx_n = idx + PULSES_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cmd_stop)      state_n   = ST_IDLE;
        else if (ext_edge) do_reload = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    // A (re)start always begins a fresh cycle; bad config drops back to IDLE.
    if (do_reload) begin
      cnt_n = '0;
      idx_n = '0;
      if (cfg_ok) begin
        load    = 1'b1;
        state_n = ST_RUN;
        irq_m_n = 1'b1;
      end else begin
        state_n = ST_IDLE;
        err_set = 1'b1;
      end
    end

    // Outputs are registered, so they are derived from the next-state values.
    wm_n     = load ? cfg_blank_master : sh_blank_master;
    per_n    = load ? cfg_period       : sh_period;
    np_n     = load ? cfg_n_pulses     : sh_n_pulses;
    width_n  = (idx_n == '0) ? wm_n : sh_blank;
    active_n = (state_n == ST_RUN) && (cnt_n < width_n);
    irq_c_n  = (state_n == ST_RUN) && (cnt_n == per_n - CNT_W'(1)) &&
               (idx_n == np_n - PULSES_W'(1));
    level_n  = active_n ? cfg_polarity : ~cfg_polarity;
  end

  always_ff @(posedge clk50_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      idx             <= '0;
      sh_period       <= '0;
      sh_blank_master <= '0;
      sh_blank        <= '0;
      sh_n_pulses     <= '0;
      sync_out        <= 1'b0;
      sync_ch         <= '0;
      running         <= 1'b0;
      cycle_cnt       <= '0;
      cfg_err         <= 1'b0;
      irq_master      <= 1'b0;
      irq_cycle       <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      if (load) begin
        sh_period       <= cfg_period;
        sh_blank_master <= cfg_blank_master;
        sh_blank        <= cfg_blank;
        sh_n_pulses     <= cfg_n_pulses;
      end
      sync_out   <= level_n;
      sync_ch    <= (cfg_ch_enable & {CHANNELS{level_n}}) |
                    (~cfg_ch_enable & {CHANNELS{~cfg_polarity}});
      running    <= (state_n != ST_IDLE);
      irq_master <= irq_m_n;
      irq_cycle  <= irq_c_n;
      if (cmd_clear)    cycle_cnt <= '0;
      else if (cyc_inc) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (cmd_clear)    cfg_err <= 1'b0;
      else if (err_set) cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_pulse_gen_mch.sv
// Self-checking bench for sync_pulse_gen_mch: start-validity table, hand sequences and random configs vs a timing model.
// The external sync section is compiled only when SYNC_EXT_IN_EN is defined.
module tb_sync_pulse_gen_mch;
  localparam int CH = 8;
  localparam int CW = 32;
  localparam int PW = 4;
  localparam int W  = CH + 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cfg_period, cfg_blank_master, cfg_blank;
  logic [PW-1:0] cfg_n_pulses;
  logic          cfg_polarity;
  logic [CH-1:0] cfg_ch_enable;
  logic          cmd_start, cmd_stop, cmd_clear;
  logic          sync_out, running, cfg_err, irq_master, irq_cycle;
  logic [CH-1:0] sync_ch;
  logic [PW-1:0] pulse_idx;
  logic [CW-1:0] cycle_cnt;
`ifdef SYNC_EXT_IN_EN
  logic          sync_in;
  logic          cfg_ext_mode;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [CW-1:0] period;
    logic [PW-1:0] n_pulses;
    logic          exp_run;
    logic          exp_err;
  } start_vec_t;
  start_vec_t vecs[6];

  sync_pulse_gen_mch #(.CHANNELS(CH), .CNT_W(CW), .PULSES_W(PW)) dut (
    .clk50_clk        (clk),
    .rst_reset_n      (rst_n),
    .cfg_period       (cfg_period),
    .cfg_blank_master (cfg_blank_master),
    .cfg_blank        (cfg_blank),
    .cfg_n_pulses     (cfg_n_pulses),
    .cfg_polarity     (cfg_polarity),
    .cfg_ch_enable    (cfg_ch_enable),
    .cmd_start        (cmd_start),
    .cmd_stop         (cmd_stop),
    .cmd_clear        (cmd_clear),
`ifdef SYNC_EXT_IN_EN
    .sync_in          (sync_in),
    .cfg_ext_mode     (cfg_ext_mode),
`endif
    .sync_out         (sync_out),
    .sync_ch          (sync_ch),
    .running          (running),
    .pulse_idx        (pulse_idx),
    .cycle_cnt        (cycle_cnt),
    .cfg_err          (cfg_err),
    .irq_master       (irq_master),
    .irq_cycle        (irq_cycle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] exp_ch(input logic [CH-1:0] en, input logic so, input logic pol);
    return (en & {CH{so}}) | (~en & {CH{~pol}});
  endfunction

  // Expected outputs t clocks after a start, for a config held constant across cycles.
  function automatic logic [W-1:0] model_at(input int p, input int bm, input int b, input int n,
                                            input logic pol, input logic [CH-1:0] en, input int t);
    int pulse, off, w, ph;
    logic so;
    logic [PW-1:0] idx4;
    ph    = t % (p * n);
    pulse = ph / p;
    off   = ph % p;
    w     = (pulse == 0) ? bm : b;
    so    = (off < w) ? pol : ~pol;
    idx4  = PW'(pulse);
    return {exp_ch(en, so, pol), so, (ph == 0), (ph == p * n - 1), idx4};
  endfunction

  task automatic stop_and_clear();
    cmd_stop  = 1'b1;
    cmd_clear = 1'b1;
    step();
    cmd_stop  = 1'b0;
    cmd_clear = 1'b0;
  endtask

  initial begin
    int c, t, pulse, w, p, bm, b, n;
    logic so, pol;
    logic [CH-1:0] en;
    logic [W-1:0] got;

    vecs[0] = '{32'd10, 4'd3, 1'b1, 1'b0};
    vecs[1] = '{32'd1, 4'd3, 1'b0, 1'b1};
    vecs[2] = '{32'd0, 4'd3, 1'b0, 1'b1};
    vecs[3] = '{32'd2, 4'd0, 1'b0, 1'b1};
    vecs[4] = '{32'd2, 4'd1, 1'b1, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 4'd15, 1'b1, 1'b0};

    rst_n = 1'b0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
    cfg_period = 32'd10; cfg_blank_master = 32'd6; cfg_blank = 32'd3;
    cfg_n_pulses = 4'd3; cfg_polarity = 1'b1; cfg_ch_enable = 8'hA5;
`ifdef SYNC_EXT_IN_EN
    sync_in = 1'b0; cfg_ext_mode = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_sync_out", sync_out, 0);
    check("rst_sync_ch", sync_ch, 0);
    check("rst_running", running, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_irqs", {cfg_err, irq_master, irq_cycle, pulse_idx}, 0);
    rst_n = 1'b1;
    step();
    check("idle_sync_out", sync_out, 0);

    // Basic waveform, live channel-enable change, deferred blank change, stop.
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int k = 0; k <= 45; k++) begin
      c     = k / 30;
      t     = k % 30;
      pulse = t / 10;
      w     = (pulse == 0) ? 6 : ((c == 0) ? 3 : 5);
      so    = ((t % 10) < w);
      en    = (k >= 3) ? 8'hA7 : 8'hA5;
      check("t1_sync_out", sync_out, so);
      check("t1_sync_ch", sync_ch, exp_ch(en, so, 1'b1));
      check("t1_pulse_idx", pulse_idx, pulse);
      check("t1_irq_master", irq_master, (t == 0));
      check("t1_irq_cycle", irq_cycle, (t == 29));
      check("t1_cycle_cnt", cycle_cnt, c);
      if (k == 2)  cfg_ch_enable = 8'hA7;
      if (k == 12) cfg_blank = 32'd5;
      if (k == 45) cmd_stop = 1'b1;
      step();
    end
    cmd_stop = 1'b0;
    check("t4_stop_sync_out", sync_out, 0);
    check("t4_stop_running", running, 0);
    check("t4_stop_idx", pulse_idx, 0);
    check("t4_stop_cycle_cnt", cycle_cnt, 1);

    // Start-validity table.
    cfg_blank = 32'd3;
    foreach (vecs[i]) begin
      cfg_period   = vecs[i].period;
      cfg_n_pulses = vecs[i].n_pulses;
      cmd_start    = 1'b1;
      step();
      cmd_start = 1'b0;
      check("vec_running", running, vecs[i].exp_run);
      check("vec_cfg_err", cfg_err, vecs[i].exp_err);
      check("vec_sync_out", sync_out, vecs[i].exp_run);
      stop_and_clear();
      check("vec_clear_err", cfg_err, 0);
    end

    // Simultaneous start/stop in IDLE stays idle.
    cfg_period = 32'd10; cfg_n_pulses = 4'd3;
    cmd_start = 1'b1; cmd_stop = 1'b1;
    step();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    check("t5_startstop_running", running, 0);
    check("t5_startstop_sync_out", sync_out, 0);

    // Active-low pulses.
    cfg_polarity = 1'b0; cfg_ch_enable = 8'h0F;
    step();
    check("t5_idle_high", sync_out, 1);
    check("t5_idle_high_ch", sync_ch, 8'hFF);
    cfg_period = 32'd4; cfg_blank_master = 32'd2; cfg_blank = 32'd1; cfg_n_pulses = 4'd2;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      got = model_at(4, 2, 1, 2, 1'b0, 8'h0F, k);
      check("t5_low_wave", {sync_ch, sync_out}, got[W-1:6]);
      step();
    end
    stop_and_clear();

    // Clear coincident with a cycle_cnt increment.
    cfg_polarity = 1'b1;
    cfg_period = 32'd2; cfg_blank_master = 32'd1; cfg_n_pulses = 4'd1;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    step();
    check("clr_irq_cycle", irq_cycle, 1);
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    check("clr_wins", cycle_cnt, 0);
    step();
    step();
    check("clr_next_inc", cycle_cnt, 1);
    stop_and_clear();

    // Invalid config at reload stops the block.
    cfg_period = 32'd3;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    cfg_period = 32'd1;
    step();
    step();
    check("reload_still_running", running, 1);
    step();
    check("reload_bad_running", running, 0);
    check("reload_bad_err", cfg_err, 1);
    check("reload_bad_sync", sync_out, 0);
    stop_and_clear();

    // Randomized configs against the timing model.
    for (int trial = 0; trial < 10; trial++) begin
      p   = $urandom_range(12, 2);
      n   = $urandom_range(4, 1);
      bm  = $urandom_range(p + 2, 0);
      b   = $urandom_range(p + 2, 0);
      pol = 1'($urandom_range(1, 0));
      en  = 8'($urandom);
      cfg_period = p; cfg_blank_master = bm; cfg_blank = b; cfg_n_pulses = PW'(n);
      cfg_polarity = pol; cfg_ch_enable = en;
      step();
      for (int k = 0; k < 2 * p * n; k++) exp_q.push_back(model_at(p, bm, b, n, pol, en, k));
      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      while (exp_q.size() > 0) begin
        got = {sync_ch, sync_out, irq_master, irq_cycle, pulse_idx};
        check("rand_wave", got, exp_q.pop_front());
        step();
      end
      check("rand_cycle_cnt", cycle_cnt, 2);
      stop_and_clear();
    end

`ifdef SYNC_EXT_IN_EN
    // External edge from IDLE, hold at end of cycle, re-trigger.
    cfg_polarity = 1'b1; cfg_ch_enable = 8'hFF; cfg_ext_mode = 1'b1;
    cfg_period = 32'd4; cfg_blank_master = 32'd2; cfg_n_pulses = 4'd1;
    step();
    sync_in = 1'b1;
    step();
    step();
    check("ext_latency_early", sync_out, 0);
    step();
    check("ext_latency_3", sync_out, 1);
    repeat (4) step();
    check("ext_hold_sync", sync_out, 0);
    check("ext_hold_running", running, 1);
    repeat (6) step();
    check("ext_no_wrap", {sync_out, irq_master}, 0);
    sync_in = 1'b0;
    repeat (3) step();
    sync_in = 1'b1;
    repeat (3) step();
    check("ext_retrigger", {sync_out, irq_master}, 2'b11);
    cfg_ext_mode = 1'b0;
    stop_and_clear();
`endif

    // Asynchronous reset mid-pulse.
    cfg_polarity = 1'b1;
    cfg_period = 32'd10; cfg_blank_master = 32'd6; cfg_n_pulses = 4'd3;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    step();
    step();
    check("pre_rst_high", sync_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sync_out", sync_out, 0);
    check("async_rst_sync_ch", sync_ch, 0);
    check("async_rst_running", running, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_running", running, 0);
    check("post_rst_counts", {cycle_cnt, pulse_idx}, 0);
    check("post_rst_err", cfg_err, 0);
    check("post_rst_sync_out", sync_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
